// File: rtl/router_ctrl.sv
// Ingress controller of the 1x3 packet router: decodes the header, sequences writes into the
// three output FIFOs, checks parity/length and raises per-FIFO soft_reset on read timeout.

module router_tmr #(
  parameter int TIMEOUT = 30
) (
  input  logic clock,
  input  logic reset,
  input  logic vld,
  input  logic rd,
  output logic sr
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] tmr_q, tmr_d;

  // The pulse fires in the TIMEOUT-th consecutive unread cycle, then the count restarts.
  assign sr = vld & ~rd & (tmr_q == TW'(TIMEOUT - 1));

  always_comb begin
    tmr_d = tmr_q + 1'b1;
    if (~vld | rd | sr) tmr_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tmr_q <= '0;
    else       tmr_q <= tmr_d;
  end
endmodule

module router_ctrl #(
  parameter int TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  output logic [7:0] data_out,
  output logic [2:0] write_enb,
  output logic       lfd_state,
  output logic       busy,
  output logic       err,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset
);
  localparam int NUM_FIFO = 3;

  localparam logic [2:0] DECODE       = 3'd0;
  localparam logic [2:0] WAIT_EMPTY   = 3'd1;
  localparam logic [2:0] LOAD_FIRST   = 3'd2;
  localparam logic [2:0] LOAD_DATA    = 3'd3;
  localparam logic [2:0] CHECK_PARITY = 3'd4;
  localparam logic [2:0] DISCARD      = 3'd5;

  typedef struct packed {
    logic [5:0] len;
    logic [1:0] addr;
  } hdr_t;

  logic [2:0] state_q, state_d;
  hdr_t       hdr_q, hdr_d, hdr_in;
  logic [7:0] parity_q, parity_d;
  logic [5:0] len_q, len_d;
  logic       ovf_q, ovf_d;
  logic       err_q, err_d;
  logic       pend_q, pend_d;
  logic [7:0] dout_q, dout_d;

  logic [3:0] full_x, empty_x, sr_x, we_x;
  logic       active, sr_hit, full_a, wr_fire;

  assign hdr_in = hdr_t'(data_in);

  // Widen the per-FIFO flags to 4 entries so addr 3 indexes a harmless constant.
  assign full_x  = {1'b0, fifo_full};
  assign empty_x = {1'b1, fifo_empty};
  assign sr_x    = {1'b0, soft_reset};
  assign we_x    = 4'b0001 << hdr_q.addr;

  assign active  = (state_q == WAIT_EMPTY) || (state_q == LOAD_FIRST) ||
                   (state_q == LOAD_DATA)  || (state_q == CHECK_PARITY);
  assign sr_hit  = active & sr_x[hdr_q.addr];
  assign full_a  = full_x[hdr_q.addr];
  assign wr_fire = pend_q & ~full_a & ~sr_hit;

  assign write_enb = wr_fire ? we_x[2:0] : 3'b000;
  assign data_out  = dout_q;
  assign lfd_state = (state_q == LOAD_FIRST);
  assign err       = err_q;
  assign vld_out   = ~fifo_empty;

  always_comb begin
    case (state_q)
      WAIT_EMPTY, LOAD_FIRST, CHECK_PARITY: busy = 1'b1;
      LOAD_DATA:                            busy = pend_q & full_a;
      default:                              busy = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    parity_d = parity_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    dout_d   = dout_q;
    pend_d   = pend_q & ~wr_fire;
    if (sr_hit) begin
      // The active FIFO was flushed: drop the pending byte and the rest of the packet.
      pend_d  = 1'b0;
      state_d = pkt_valid ? DISCARD : DECODE;
    end else begin
      case (state_q)
        DECODE: begin
          if (pkt_valid) begin
            hdr_d = hdr_in;
            if (hdr_in.addr == 2'd3) begin
              state_d = DISCARD;
            end else begin
              parity_d = data_in;
              len_d    = hdr_in.len;
              ovf_d    = 1'b0;
              err_d    = 1'b0;
              state_d  = empty_x[hdr_in.addr] ? LOAD_FIRST : WAIT_EMPTY;
            end
          end
        end
        WAIT_EMPTY: begin
          if (empty_x[hdr_q.addr]) state_d = LOAD_FIRST;
        end
        LOAD_FIRST: begin
          dout_d  = hdr_q;
          pend_d  = 1'b1;
          state_d = LOAD_DATA;
        end
        LOAD_DATA: begin
          if (!busy) begin
            dout_d = data_in;
            pend_d = 1'b1;
            if (pkt_valid) begin
              parity_d = parity_q ^ data_in;
              // Extra payload saturates the count and is remembered for the end check.
              if (len_q != 6'd0) len_d = len_q - 6'd1;
              else               ovf_d = 1'b1;
            end else begin
              err_d   = (data_in != parity_q) | (len_q != 6'd0) | ovf_q;
              state_d = CHECK_PARITY;
            end
          end
        end
        CHECK_PARITY: begin
          if (!pend_d) state_d = DECODE;
        end
        DISCARD: begin
          if (!pkt_valid) state_d = DECODE;
        end
        default: state_d = DECODE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= DECODE;
      hdr_q    <= '0;
      parity_q <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      parity_q <= parity_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
      dout_q   <= dout_d;
    end
  end

  for (genvar i = 0; i < NUM_FIFO; i++) begin : g_tmr
    router_tmr #(.TIMEOUT(TIMEOUT)) u_tmr (
      .clock (clock),
      .reset (reset),
      .vld   (vld_out[i]),
      .rd    (read_enb[i]),
      .sr    (soft_reset[i])
    );
  end
endmodule
